// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable integer clock divider with 50% duty for even and odd ratios.
// Ports:
//   i_ref_clk   - reference clock (posedge logic, plus one negedge flop for odd ratios)
//   i_rst_n     - asynchronous active-low reset
//   i_clk_en    - divider enable request, 0 selects bypass
//   i_div_ratio - requested divide ratio R (unsigned)
//   o_div_clk   - divided clock, or i_ref_clk in bypass
//   o_div_rise  - one-ref-cycle strobe for the cycle in which o_div_clk rises
//   o_ratio_act - ratio currently in effect, 0 in bypass
module clk_div_gen #(
    parameter int RATIO_W = 8
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_div_ratio,
    output logic               o_div_clk,
    output logic               o_div_rise,
    output logic [RATIO_W-1:0] o_ratio_act
);
    logic               r_en_act;
    logic [RATIO_W-1:0] r_act;
    logic [RATIO_W-1:0] r_cnt;
    logic               r_p;
    logic               r_n;
    logic               w_div;
    logic               w_upd;
    logic               w_en_nxt;
    logic               w_div_nxt;
    logic [RATIO_W-1:0] w_r_nxt;
    logic [RATIO_W-1:0] w_cnt_nxt;

    assign w_div     = r_en_act && (r_act >= RATIO_W'(2));
    // Shadow registers reload only on the last cycle of a period, or every cycle in bypass.
    assign w_upd     = !w_div || (r_cnt == r_act - RATIO_W'(1));
    assign w_en_nxt  = w_upd ? i_clk_en : r_en_act;
    assign w_r_nxt   = w_upd ? i_div_ratio : r_act;
    assign w_div_nxt = w_en_nxt && (w_r_nxt >= RATIO_W'(2));
    assign w_cnt_nxt = w_upd ? '0 : r_cnt + RATIO_W'(1);

    // p is registered from next-state values so the first divided cycle after
    // bypass or a ratio change starts high on the same posedge as cnt=0.
    // floor(R/2) serves both even R (R/2) and odd R ((R-1)/2).
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_act <= 1'b0;
            r_act    <= '0;
            r_cnt    <= '0;
            r_p      <= 1'b0;
        end else begin
            r_en_act <= w_en_nxt;
            r_act    <= w_r_nxt;
            r_cnt    <= w_cnt_nxt;
            r_p      <= w_div_nxt && (w_cnt_nxt < (w_r_nxt >> 1));
        end
    end

    // Half-cycle delayed copy of p stretches the odd-ratio high time by half a ref period.
    always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_n <= 1'b0;
        else          r_n <= r_p;
    end

    assign o_div_clk   = w_div ? (r_p | (r_act[0] & r_n)) : i_ref_clk;
    assign o_div_rise  = !w_div || (r_cnt == '0);
    assign o_ratio_act = w_div ? r_act : '0;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed self-checking bench for clk_div_gen.
module tb_clk_div_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] ratio;
    logic       div_clk;
    logic       div_rise;
    logic [7:0] ratio_act;
    int         n_tests = 0;
    int         n_fail = 0;

    clk_div_gen #(.RATIO_W(8)) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_clk_en   (en),
        .i_div_ratio(ratio),
        .o_div_clk  (div_clk),
        .o_div_rise (div_rise),
        .o_ratio_act(ratio_act)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One ref cycle: sample 2 ns after posedge (first half) and 7 ns after (second half).
    task automatic cyc(input logic e1, input logic e2, input logic er, input logic [7:0] eratio, input string tag);
        @(posedge clk);
        #2;
        n_tests++;
        assert (div_clk === e1) else begin n_fail++; $error("FAIL %s clk_h1 got %b exp %b", tag, div_clk, e1); end
        n_tests++;
        assert (div_rise === er) else begin n_fail++; $error("FAIL %s rise got %b exp %b", tag, div_rise, er); end
        n_tests++;
        assert (ratio_act === eratio) else begin n_fail++; $error("FAIL %s ratio got %0d exp %0d", tag, ratio_act, eratio); end
        #5;
        n_tests++;
        assert (div_clk === e2) else begin n_fail++; $error("FAIL %s clk_h2 got %b exp %b", tag, div_clk, e2); end
    endtask

    // A full divided period of r cycles; high for r half-periods starting at cnt=0.
    // At cycle index 'at' the inputs are changed to (ne, nr).
    task automatic per(input int r, input int at, input logic ne, input int nr, input string tag);
        for (int c = 0; c < r; c++) begin
            cyc(2*c < r, 2*c+1 < r, c == 0, 8'(r), tag);
            if (c == at) begin
                en = ne;
                ratio = 8'(nr);
            end
        end
    endtask

    task automatic byp(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 8'd0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ratio = 8'd0;
        byp(2, "in_reset");
        en    = 1'b1;
        ratio = 8'd4;
        rst_n = 1'b1;
        per(4, -1, 1'b1, 4, "r4_a");
        per(4, 1, 1'b1, 6, "r4_chg");
        per(6, -1, 1'b1, 6, "r6_a");
        per(6, 3, 1'b1, 5, "r6_chg");
        per(5, -1, 1'b1, 5, "r5_a");
        per(5, 0, 1'b1, 3, "r5_chg");
        per(3, -1, 1'b1, 3, "r3_a");
        per(3, 1, 1'b1, 0, "r3_to0");
        byp(3, "byp_r0");
        ratio = 8'd1;
        byp(3, "byp_r1");
        en    = 1'b0;
        ratio = 8'd8;
        byp(1, "byp_en0");
        en    = 1'b1;
        per(8, 3, 1'b0, 8, "r8_en_off");
        byp(3, "byp_after_r8");
        en    = 1'b1;
        per(8, 7, 1'b1, 7, "r8_en_on");
        for (int c = 0; c < 3; c++) cyc(2*c < 7, 2*c+1 < 7, c == 0, 8'd7, "r7_pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        assert (ratio_act === 8'd0) else begin n_fail++; $error("FAIL rst_async ratio got %0d exp 0", ratio_act); end
        n_tests++;
        assert (div_rise === 1'b1) else begin n_fail++; $error("FAIL rst_async rise got %b exp 1", div_rise); end
        n_tests++;
        assert (div_clk === 1'b1) else begin n_fail++; $error("FAIL rst_async clk_hi got %b exp 1", div_clk); end
        #5;
        n_tests++;
        assert (div_clk === 1'b0) else begin n_fail++; $error("FAIL rst_async clk_lo got %b exp 0", div_clk); end
        byp(1, "rst_hold");
        rst_n = 1'b1;
        per(7, -1, 1'b1, 7, "r7_restart");
        per(7, -1, 1'b1, 7, "r7_b");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter: RATIO_W, default 8, width of the divide-ratio input and internal counter.
REQ-002 Port: i_ref_clk  input  1  reference clock; all logic runs on its posedge, except the odd-ratio half-cycle flop (negedge).
REQ-003 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_clk_en  input  1  divider enable request; 0 requests bypass.
REQ-005 Port: i_div_ratio  input  RATIO_W  requested divide ratio R, unsigned.
REQ-006 Port: o_div_clk  output  1  divided clock, or i_ref_clk when in bypass.
REQ-007 Port: o_div_rise  output  1  one-ref-cycle strobe marking the ref cycle in which o_div_clk rises.
REQ-008 Port: o_ratio_act  output  RATIO_W  currently active ratio; 0 when in bypass.

Function
REQ-009 The block SHALL keep shadow registers en_act and r_act; all divide behaviour SHALL use only these registers, never live inputs.
REQ-010 Divided mode SHALL be active only when en_act=1 and r_act>=2; otherwise the block is in bypass.
REQ-011 Bypass: o_div_clk = i_ref_clk combinationally; counter held at 0; o_div_rise=1; o_ratio_act=0.
REQ-012 Divided mode: counter cnt counts 0..r_act-1 and wraps to 0; counter width is RATIO_W, so no truncation for any R up to 2^RATIO_W-1.
REQ-013 Even r_act: o_div_clk high while cnt < r_act/2 and low otherwise, giving an exact 50% duty cycle.
REQ-014 Odd r_act: the posedge phase flop p SHALL be high while cnt < (r_act-1)/2.
REQ-015 Odd r_act: the negedge flop n SHALL capture p on each i_ref_clk negedge.
REQ-016 Odd r_act: o_div_clk = p OR n, giving a high time of r_act/2 ref periods, with the rising edge aligned to the i_ref_clk posedge.
REQ-017 R=3 example: high 1.5 ref periods, low 1.5 ref periods.
REQ-018 Update point: i_clk_en and i_div_ratio SHALL be sampled into en_act and r_act only at the posedge ending the cycle in which cnt==r_act-1 (divided mode), or at every posedge in bypass.
REQ-019 A changed ratio SHALL take effect starting at cnt=0; no truncated or stretched pulse is permitted.
REQ-020 Enable deassert SHALL complete the current divided period before entering bypass.
REQ-021 Enable assert from bypass SHALL start at cnt=0 with o_div_clk high, edge-aligned to the i_ref_clk posedge; the output mux SHALL produce no runt pulse.
REQ-022 o_div_rise SHALL be 1 during ref cycles where cnt==0 in divided mode, and 0 in all other divided-mode cycles.
REQ-023 Ratio changes while in divided mode SHALL be ignored until the update point of REQ-018; intermediate values are never observed.
REQ-024 R=0 or R=1 with i_clk_en=1 SHALL select bypass, per REQ-010.

Reset
REQ-025 Asynchronous assertion of i_rst_n=0 SHALL immediately clear cnt, p, n, en_act and r_act to 0.
REQ-026 While i_rst_n=0, the block is in bypass: o_div_clk follows i_ref_clk, o_div_rise=1, o_ratio_act=0.
REQ-027 Reset asserted mid-period SHALL abort the period with no completion requirement.
REQ-028 On reset release, the first posedge SHALL sample the inputs per REQ-018 (bypass rule).

Verification
REQ-029 Even ratio: en=1, R=4 -> o_div_clk period 4 ref cycles, 2 high / 2 low; o_div_rise 1 of every 4 cycles; o_ratio_act=4.
REQ-030 Odd ratio: en=1, R=5 -> period 5 ref cycles, high 2.5 / low 2.5; rising edges coincide with i_ref_clk posedges.
REQ-031 Ratio change mid-period: R changes 4->6 when cnt=1 -> current 4-cycle period completes unchanged, next period is 6 cycles; o_ratio_act switches 4->6 at the boundary.
REQ-032 Bypass ratios: R=0 and R=1 with en=1 -> o_div_clk equals i_ref_clk, o_ratio_act=0, o_div_rise held at 1.
REQ-033 Enable toggle: en 1->0 mid-period with R=8 -> the period completes, then bypass; en 0->1 -> divided output starts high at the next posedge with no glitch, checked by pulse-width assertion of at least 1 ref period high/low in divided mode.
REQ-034 Reset mid-operation: i_rst_n pulsed low at cnt=3 of R=7 -> outputs enter bypass immediately; after release with R=7, en=1 -> a full 7-cycle period restarts from cnt=0.
